ex_stage: RTL
=============

# ex_stage

Execute stage of the five-stage MIPS pipeline. It sits directly downstream of instruction decode and upstream of memory access. It registers the decode-to-execute bus under the shared stall vector and evaluates the 12-operation ALU. It also issues the data-SRAM request with byte-lane alignment and returns its own result to decode as the first-priority forwarding source, together with the load-use hazard flag.

## Interface
Parameters (from the shared defines header):
- `ID_TO_EX_WD`, 159: width of the decode-to-execute bus.
- `EX_TO_MEM_WD`, 76: width of the execute-to-memory bus.
- `EX_TO_RF_WD`, 38: width of the forwarding bus, `{we, waddr[4:0], wdata[31:0]}`.
- `StallBus`, 6: width of the stall vector. `Stop`=1, `NoStop`=0.
- `LoadBus` 5 / `SaveBus` 3: load and store one-hot groups.

Ports:
- `clk` in 1: clock; the only clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `stall` in `StallBus`: bit 2 is this stage, bit 3 is the memory stage.
- `id_to_ex_bus` in 159, packed MSB to LSB:
  - `pc` 32, `inst` 32, `alu_op` 12, `sel_src1` 3, `sel_src2` 4,
  - `ram_en` 1, `ram_wen` 4, `rf_we` 1, `rf_waddr` 5, `sel_rf_res` 1,
  - `data1` 32, `data2` 32.
- `id_load_bus` in 5: `{lb, lbu, lh, lhu, lw}`.
- `id_save_bus` in 3: `{sb, sh, sw}`.
- `ex_to_mem_bus` out 76: `{pc, ram_en, wen_aligned[3:0], sel_rf_res, rf_we, rf_waddr, ex_result}`.
- `ex_to_rf_bus` out 38: `{rf_we, rf_waddr, ex_result}`.
- `ex_load_bus` out 5 / `ex_save_bus` out 3: registered copies of the input groups.
- `ex_is_load` out 1: registered load instruction present. Drives decode's `pre_inst_is_load`.
- `data_sram_en` out 1, `data_sram_wen` out 4, `data_sram_addr` out 32, `data_sram_wdata` out 32.

## Operation
Input register update, one bus register holding the decode bus plus both groups, on each `clk`:
- `rst`: clear to all zeros.
- `stall[2]=Stop` and `stall[3]=NoStop`: load zeros, i.e. insert a bubble.
- `stall[2]=NoStop`: capture the inputs.
- Otherwise: hold.

Operand select. Each select field is one-hot; an all-zero field gives 0.
- src1:
  - bit0: `data1`
  - bit1: `pc`
  - bit2: zero-extended `inst[10:6]`
- src2:
  - bit0: `data2`
  - bit1: sign-extended `inst[15:0]`
  - bit2: `32'd8`
  - bit3: zero-extended `inst[15:0]`

ALU. `alu_op` bits [11:0] are add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui. The result is the OR of the gated per-op results.
- add/sub: modulo 2^32; no overflow trap.
- slt: signed compare. sltu: unsigned compare. Both give 0 or 1.
- Shifts: src2 shifted by `src1[4:0]`. sra is arithmetic.
- lui: `{src2[15:0], 16'b0}`.

Memory request:
- `addr = ex_result`.
- `data_sram_en = ram_en`.
- `data_sram_wen` is aligned as follows:
  - sb: `4'b0001 << addr[1:0]`
  - sh: `4'b0011 << {addr[1],1'b0}`
  - sw: `4'b1111`
  - loads: `4'b0000`
- `data_sram_wdata`:
  - sb: `{4{data2[7:0]}}`
  - sh: `{2{data2[15:0]}}`
  - otherwise: `data2`
- Misaligned sh/sw: no exception; the address is passed unchanged.

Flags:
- `ex_is_load` = OR of the registered `ex_load_bus`.
- `ex_to_rf_bus.we` = registered `rf_we`.
- For a load, `ex_result` is the address, not data. Decode stalls on `ex_is_load`.

## Timing
- Reset: every output is 0 in the cycle after `rst` is sampled high. An all-zero register yields an all-zero ALU result and idle SRAM.
- Latency: one cycle from decode to valid outputs. All outputs are combinational from the bus register.
- SRAM read data returns in the memory stage, in the cycle after `data_sram_en`.
- Hold (`stall[3:2]` both Stop): outputs, including the SRAM request, stay constant. Memory-side repeated reads must be idempotent.
- Bubble: the `rf_we=0`, `ram_en=0` instruction reaches memory the next cycle.
- `rst` asserted mid-stall takes priority over hold.

## Structure
- Shared `lib/defines.vh` holds the bus widths, `StallBus`, `Stop`/`NoStop`, `LoadBus` and `SaveBus`.
- One sub-module: `alu` (combinational; inputs `alu_op`, `src1`, `src2`; output `result`).
- `ex_stage` contains the register, operand mux, alignment and bus packing.

## Test plan
- addiu, `data1=0xFFFFFFFF`, imm `0x0001` → `ex_result=0`, `ex_to_rf_bus={1, rt, 0}` one cycle later.
- jal at `pc=0xBFC00010` (src1=pc, src2=8, op add) → `ex_result=0xBFC00018`, `rf_waddr=31`.
- sb, `data1=0x1000`, imm 3, `data2=0x123456AB`:
  - `data_sram_wen=4'b1000`, `addr=0x1003`, `wdata=0xABABABAB`.
- sra, sa=4, `data2=0x80000000` → `0xF8000000`. slt with -1 vs 1 → 1. sltu with -1 vs 1 → 0.
- lw followed by stall `000111` → `ex_is_load=1` while the lw is in execute; the next cycle the outputs are a bubble (`ex_is_load=0`, `data_sram_en=0`).
- `stall=001111` for 3 cycles with sw registered → identical `data_sram_*` on each cycle; `rst` in cycle 2 → all outputs 0 the next cycle.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared widths, bus layouts and helpers for the MIPS execute stage.
package ex_stage_pkg;

   localparam int unsigned ID_TO_EX_WD  = 159;
   localparam int unsigned EX_TO_MEM_WD = 76;
   localparam int unsigned EX_TO_RF_WD  = 38;
   localparam int unsigned StallBus     = 6;
   localparam int unsigned LoadBus      = 5;
   localparam int unsigned SaveBus      = 3;

   localparam logic Stop   = 1'b1;
   localparam logic NoStop = 1'b0;

   // Bit positions inside the one-hot alu_op field (add is the MSB).
   typedef enum logic [3:0] {
      ALU_LUI  = 4'd0,
      ALU_SRA  = 4'd1,
      ALU_SRL  = 4'd2,
      ALU_SLL  = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_NOR  = 4'd6,
      ALU_AND  = 4'd7,
      ALU_SLTU = 4'd8,
      ALU_SLT  = 4'd9,
      ALU_SUB  = 4'd10,
      ALU_ADD  = 4'd11
   } alu_bit_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [11:0] alu_op;
      logic [2:0]  sel_src1;
      logic [3:0]  sel_src2;
      logic        ram_en;
      logic [3:0]  ram_wen;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic        sel_rf_res;
      logic [31:0] data1;
      logic [31:0] data2;
   } id_to_ex_t;

   typedef struct packed {
      id_to_ex_t          id;
      logic [LoadBus-1:0] load;
      logic [SaveBus-1:0] save;
   } ex_reg_t;

   // save group is {sb, sh, sw}
   function automatic logic [3:0] align_wen(input logic [SaveBus-1:0] save,
                                            input logic [1:0]         addr_lo);
      logic [3:0] wen;
      wen = '0;
      if (save[2])      wen = 4'b0001 << addr_lo;
      else if (save[1]) wen = 4'b0011 << {addr_lo[1], 1'b0};
      else if (save[0]) wen = 4'b1111;
      return wen;
   endfunction

   function automatic logic [31:0] align_wdata(input logic [SaveBus-1:0] save,
                                               input logic [31:0]        data);
      logic [31:0] wd;
      if (save[2])      wd = {4{data[7:0]}};
      else if (save[1]) wd = {2{data[15:0]}};
      else              wd = data;
      return wd;
   endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational 12-operation ALU; the result is the OR of the gated per-op results.
module alu
   import ex_stage_pkg::*;
(
   input  logic [11:0] alu_op,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   output logic [31:0] result
);

   logic [31:0] add_res;
   logic [31:0] sub_res;
   logic [31:0] sra_res;
   logic        slt_res;
   logic        sltu_res;

   always_comb begin
      add_res  = src1 + src2;
      sub_res  = src1 - src2;
      slt_res  = $signed(src1) < $signed(src2);
      sltu_res = src1 < src2;
      sra_res  = $unsigned($signed(src2) >>> src1[4:0]);

      result = '0;
      result |= {32{alu_op[ALU_ADD]}}  & add_res;
      result |= {32{alu_op[ALU_SUB]}}  & sub_res;
      result |= {32{alu_op[ALU_SLT]}}  & {31'b0, slt_res};
      result |= {32{alu_op[ALU_SLTU]}} & {31'b0, sltu_res};
      result |= {32{alu_op[ALU_AND]}}  & (src1 & src2);
      result |= {32{alu_op[ALU_NOR]}}  & ~(src1 | src2);
      result |= {32{alu_op[ALU_OR]}}   & (src1 | src2);
      result |= {32{alu_op[ALU_XOR]}}  & (src1 ^ src2);
      result |= {32{alu_op[ALU_SLL]}}  & (src2 << src1[4:0]);
      result |= {32{alu_op[ALU_SRL]}}  & (src2 >> src1[4:0]);
      result |= {32{alu_op[ALU_SRA]}}  & sra_res;
      result |= {32{alu_op[ALU_LUI]}}  & {src2[15:0], 16'b0};
   end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: decode bus register, operand select, ALU,
// data-SRAM request alignment and forwarding/memory bus packing.
module ex_stage
   import ex_stage_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [StallBus-1:0]     stall,
   input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
   input  logic [LoadBus-1:0]      id_load_bus,
   input  logic [SaveBus-1:0]      id_save_bus,
   output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
   output logic [LoadBus-1:0]      ex_load_bus,
   output logic [SaveBus-1:0]      ex_save_bus,
   output logic                    ex_is_load,
   output logic                    data_sram_en,
   output logic [3:0]              data_sram_wen,
   output logic [31:0]             data_sram_addr,
   output logic [31:0]             data_sram_wdata
);

   ex_reg_t     bus_q;
   ex_reg_t     bus_d;
   logic [31:0] src1;
   logic [31:0] src2;
   logic [31:0] ex_result;
   logic [3:0]  wen_aligned;
   logic        unused_bits;

   // Bubble only when this stage stops but memory keeps flowing.
   always_comb begin
      bus_d = bus_q;
      if (stall[2] == Stop && stall[3] == NoStop) begin
         bus_d = '0;
      end else if (stall[2] == NoStop) begin
         bus_d.id   = id_to_ex_t'(id_to_ex_bus);
         bus_d.load = id_load_bus;
         bus_d.save = id_save_bus;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) bus_q <= '0;
      else     bus_q <= bus_d;
   end

   always_comb begin
      src1 = ({32{bus_q.id.sel_src1[0]}} & bus_q.id.data1)
           | ({32{bus_q.id.sel_src1[1]}} & bus_q.id.pc)
           | ({32{bus_q.id.sel_src1[2]}} & {27'b0, bus_q.id.inst[10:6]});
      src2 = ({32{bus_q.id.sel_src2[0]}} & bus_q.id.data2)
           | ({32{bus_q.id.sel_src2[1]}} & {{16{bus_q.id.inst[15]}}, bus_q.id.inst[15:0]})
           | ({32{bus_q.id.sel_src2[2]}} & 32'd8)
           | ({32{bus_q.id.sel_src2[3]}} & {16'b0, bus_q.id.inst[15:0]});
   end

   alu u_alu (
      .alu_op (bus_q.id.alu_op),
      .src1   (src1),
      .src2   (src2),
      .result (ex_result)
   );

   assign wen_aligned     = align_wen(bus_q.save, ex_result[1:0]);
   assign data_sram_en    = bus_q.id.ram_en;
   assign data_sram_wen   = wen_aligned;
   assign data_sram_addr  = ex_result;
   assign data_sram_wdata = align_wdata(bus_q.save, bus_q.id.data2);

   assign ex_load_bus = bus_q.load;
   assign ex_save_bus = bus_q.save;
   assign ex_is_load  = |bus_q.load;

   assign ex_to_mem_bus = {bus_q.id.pc, bus_q.id.ram_en, wen_aligned, bus_q.id.sel_rf_res,
                           bus_q.id.rf_we, bus_q.id.rf_waddr, ex_result};
   assign ex_to_rf_bus  = {bus_q.id.rf_we, bus_q.id.rf_waddr, ex_result};

   // Upper opcode bits and decode's raw wen are superseded by the aligned lane mask.
   assign unused_bits = ^{bus_q.id.inst[31:16], bus_q.id.ram_wen};

endmodule
